// File: rtl/uart_rx_os32.sv
// UART receiver driven by a 32x oversample tick: start-bit qualification,
// centre sampling, valid/ready delivery and framing/parity/overrun flags.
module uart_rx_os32 #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK_X32,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    state_t               state;
    logic [4:0]           tick_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 rx_meta;
    logic                 rx_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Shifting right places the first-received bit at the LSB once the word is complete.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            tick_cnt   <= 5'd0;
            bit_idx    <= 4'd0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            FRAME_ERR  <= 1'b0;
            PARITY_ERR <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR  <= 1'b0;
            PARITY_ERR <= 1'b0;
            OVERRUN    <= 1'b0;
            if (RX_VALID && RX_READY)
                RX_VALID <= 1'b0;

            if (TICK_X32) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= 5'd0;
                        end
                    end
                    START: begin
                        if (tick_cnt == 5'd15) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= 5'd0;
                                bit_idx  <= 4'd0;
                                par_bad  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == 5'd31) begin
                            tick_cnt <= 5'd0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= 4'd0;
                                state   <= HAS_PAR ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == 5'd31) begin
                            tick_cnt <= 5'd0;
                            par_bad  <= ((^{shreg, rx_s}) != ODD);
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == 5'd31) begin
                            tick_cnt <= 5'd0;
                            if (!rx_s) begin
                                FRAME_ERR <= 1'b1;
                                bit_idx   <= 4'd0;
                                state     <= WAIT_HI;
                            end else if (bit_idx == LAST_STOP) begin
                                bit_idx <= 4'd0;
                                state   <= IDLE;
                                if (par_bad) begin
                                    PARITY_ERR <= 1'b1;
                                end else if (!RX_VALID || RX_READY) begin
                                    RX_DATA  <= shreg;
                                    RX_VALID <= 1'b1;
                                end else begin
                                    OVERRUN <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                    WAIT_HI: begin
                        if (rx_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os32.sv
// Self-checking bench for uart_rx_os32: an 8N1 instance and an 8E1 instance
// driven by bit-level frames and checked against a frame-rule model.
module tb_uart_rx_os32;

    localparam int BIT = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    int         tick_div = 0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, fe_a, pe_a, ov_a, busy_a;
    logic       valid_b, fe_b, pe_b, ov_b, busy_b;

    int checks = 0;
    int errors = 0;

    int         acc_a = 0, fec_a = 0, pec_a = 0, ovc_a = 0;
    int         acc_b = 0, fec_b = 0, pec_b = 0, ovc_b = 0;
    int         multi_err = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;

    int s_acc, s_fe, s_pe, s_ov;

    uart_rx_os32 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST(rst_n), .TICK_X32(tick), .RX(rx_a),
        .RX_DATA(data_a), .RX_VALID(valid_a), .RX_READY(rdy_a),
        .FRAME_ERR(fe_a), .PARITY_ERR(pe_a), .OVERRUN(ov_a), .BUSY(busy_a));

    uart_rx_os32 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .CLK(clk), .RST(rst_n), .TICK_X32(tick), .RX(rx_b),
        .RX_DATA(data_b), .RX_VALID(valid_b), .RX_READY(rdy_b),
        .FRAME_ERR(fe_b), .PARITY_ERR(pe_b), .OVERRUN(ov_b), .BUSY(busy_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        tick     <= (tick_div == 3);
    end

    always @(negedge clk) begin
        if (valid_a && rdy_a) begin acc_a++; last_a = data_a; end
        if (valid_b && rdy_b) begin acc_b++; last_b = data_b; end
        fec_a += int'(fe_a); pec_a += int'(pe_a); ovc_a += int'(ov_a);
        fec_b += int'(fe_b); pec_b += int'(pe_b); ovc_b += int'(ov_b);
        if ((int'(fe_a) + int'(pe_a) + int'(ov_a)) > 1 ||
            (int'(fe_b) + int'(pe_b) + int'(ov_b)) > 1)
            multi_err++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [7:0] d, input logic p, input logic stop);
        return {5'b0, stop, p, d, 1'b0};
    endfunction

    task automatic send_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_b = bits[i];
            wait_clks(BIT);
        end
    endtask

    task automatic snap_a();
        s_acc = acc_a; s_fe = fec_a; s_pe = pec_a; s_ov = ovc_a;
    endtask

    task automatic snap_b();
        s_acc = acc_b; s_fe = fec_b; s_pe = pec_b; s_ov = ovc_b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(5);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_a: got %b expected 0", valid_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_a: got %h expected 00", data_a); end
        checks++; if ({fe_a, pe_a, ov_a, busy_a} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags_a: got %b expected 0000", {fe_a, pe_a, ov_a, busy_a}); end
        checks++; if ({valid_b, fe_b, pe_b, ov_b, busy_b} !== 5'b0) begin errors++; $display("[TB] FAIL reset_b: got %b expected 00000", {valid_b, fe_b, pe_b, ov_b, busy_b}); end
        rst_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic test_basic();
        rdy_a = 1'b1;
        snap_a();
        send_bits(0, frame_a(8'hA5, 1'b1), 10);
        rx_a = 1'b1;
        wait_clks(64);
        checks++; if (acc_a - s_acc !== 1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", acc_a - s_acc); end
        checks++; if (last_a !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", last_a); end
        checks++; if ((fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov) !== 0) begin errors++; $display("[TB] FAIL basic_flags: got %0d expected 0", (fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov)); end
        checks++; if ({busy_a, valid_a} !== 2'b00) begin errors++; $display("[TB] FAIL basic_idle: got %b expected 00", {busy_a, valid_a}); end
    endtask

    task automatic test_false_start();
        snap_a();
        rx_a = 1'b0;
        wait_clks(12);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL false_start_busy: got %b expected 1", busy_a); end
        wait_clks(8);
        rx_a = 1'b1;
        wait_clks(120);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL false_start_idle: got %b expected 0", busy_a); end
        checks++; if ((acc_a - s_acc) + (fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov) !== 0) begin errors++; $display("[TB] FAIL false_start_events: got %0d expected 0", (acc_a - s_acc) + (fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov)); end
    endtask

    task automatic test_break();
        snap_a();
        send_bits(0, frame_a(8'h3C, 1'b0), 10);
        wait_clks(40 * BIT);
        checks++; if (fec_a - s_fe !== 1) begin errors++; $display("[TB] FAIL break_frame_err: got %0d expected 1", fec_a - s_fe); end
        checks++; if (acc_a - s_acc !== 0) begin errors++; $display("[TB] FAIL break_no_valid: got %0d expected 0", acc_a - s_acc); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL break_busy: got %b expected 1", busy_a); end
        rx_a = 1'b1;
        wait_clks(64);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL break_release: got %b expected 0", busy_a); end
        send_bits(0, frame_a(8'h55, 1'b1), 10);
        rx_a = 1'b1;
        wait_clks(64);
        checks++; if (acc_a - s_acc !== 1) begin errors++; $display("[TB] FAIL break_next_count: got %0d expected 1", acc_a - s_acc); end
        checks++; if (last_a !== 8'h55) begin errors++; $display("[TB] FAIL break_next_data: got %h expected 55", last_a); end
        checks++; if (fec_a - s_fe !== 1) begin errors++; $display("[TB] FAIL break_single_err: got %0d expected 1", fec_a - s_fe); end
    endtask

    task automatic test_parity();
        rdy_b = 1'b1;
        snap_b();
        send_bits(1, frame_b(8'h07, 1'b0, 1'b1), 11);
        rx_b = 1'b1;
        wait_clks(64);
        checks++; if (pec_b - s_pe !== 1) begin errors++; $display("[TB] FAIL parity_err: got %0d expected 1", pec_b - s_pe); end
        checks++; if (acc_b - s_acc !== 0) begin errors++; $display("[TB] FAIL parity_no_valid: got %0d expected 0", acc_b - s_acc); end
        send_bits(1, frame_b(8'h07, 1'b1, 1'b1), 11);
        rx_b = 1'b1;
        wait_clks(64);
        checks++; if (acc_b - s_acc !== 1) begin errors++; $display("[TB] FAIL parity_ok_count: got %0d expected 1", acc_b - s_acc); end
        checks++; if (last_b !== 8'h07) begin errors++; $display("[TB] FAIL parity_ok_data: got %h expected 07", last_b); end
        checks++; if ((pec_b - s_pe) + (fec_b - s_fe) !== 1) begin errors++; $display("[TB] FAIL parity_flag_total: got %0d expected 1", (pec_b - s_pe) + (fec_b - s_fe)); end
    endtask

    task automatic test_overrun();
        rdy_a = 1'b0;
        wait_clks(2);
        snap_a();
        send_bits(0, frame_a(8'h11, 1'b1), 10);
        rx_a = 1'b1;
        wait_clks(64);
        send_bits(0, frame_a(8'h22, 1'b1), 10);
        rx_a = 1'b1;
        wait_clks(64);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b expected 1", valid_a); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("[TB] FAIL overrun_held: got %h expected 11", data_a); end
        checks++; if (ovc_a - s_ov !== 1) begin errors++; $display("[TB] FAIL overrun_pulse: got %0d expected 1", ovc_a - s_ov); end
        rdy_a = 1'b1;
        wait_clks(1);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", valid_a); end
        checks++; if (acc_a - s_acc !== 1 || last_a !== 8'h11) begin errors++; $display("[TB] FAIL overrun_accept: got %0d/%h expected 1/11", acc_a - s_acc, last_a); end
    endtask

    task automatic test_reset_mid();
        rdy_a = 1'b1;
        send_bits(0, frame_a(8'hF0, 1'b1), 4);
        wait_clks(50);
        rst_n = 1'b0;
        #1;
        checks++; if ({valid_a, data_a, fe_a, pe_a, ov_a, busy_a} !== 13'b0) begin errors++; $display("[TB] FAIL reset_mid_outputs: got %h expected 0", {valid_a, data_a, fe_a, pe_a, ov_a, busy_a}); end
        rx_a = 1'b1;
        wait_clks(BIT);
        rst_n = 1'b1;
        wait_clks(10);
        snap_a();
        send_bits(0, frame_a(8'h0F, 1'b1), 10);
        rx_a = 1'b1;
        wait_clks(64);
        checks++; if (acc_a - s_acc !== 1 || last_a !== 8'h0F) begin errors++; $display("[TB] FAIL reset_mid_recover: got %0d/%h expected 1/0f", acc_a - s_acc, last_a); end
        checks++; if ((fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov) !== 0) begin errors++; $display("[TB] FAIL reset_mid_flags: got %0d expected 0", (fec_a - s_fe) + (pec_a - s_pe) + (ovc_a - s_ov)); end
    endtask

    // Model: a frame is either dropped (stop low), delivered, held, or overrun,
    // depending on the stop bit and whether a word is already waiting.
    task automatic test_random_8n1();
        logic       pending = 1'b0;
        logic [7:0] held = 8'h00;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       r, bad;
            int         e_acc, e_fe, e_ov;
            d   = 8'($urandom);
            r   = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 4) == 0);
            rdy_a = r;
            wait_clks(2);
            if (r) pending = 1'b0;
            snap_a();
            send_bits(0, frame_a(d, !bad), 10);
            rx_a = 1'b1;
            wait_clks(64);
            e_acc = 0; e_fe = 0; e_ov = 0;
            if (bad)          e_fe = 1;
            else if (r)       e_acc = 1;
            else if (pending) e_ov = 1;
            else begin pending = 1'b1; held = d; end
            checks++; if (acc_a - s_acc !== e_acc || fec_a - s_fe !== e_fe || ovc_a - s_ov !== e_ov) begin
                errors++; $display("[TB] FAIL rand_a_events[%0d]: got acc=%0d fe=%0d ov=%0d expected acc=%0d fe=%0d ov=%0d", i, acc_a - s_acc, fec_a - s_fe, ovc_a - s_ov, e_acc, e_fe, e_ov);
            end
            checks++; if (valid_a !== pending) begin errors++; $display("[TB] FAIL rand_a_valid[%0d]: got %b expected %b", i, valid_a, pending); end
            if (e_acc == 1) begin
                checks++; if (last_a !== d) begin errors++; $display("[TB] FAIL rand_a_data[%0d]: got %h expected %h", i, last_a, d); end
            end
            if (pending) begin
                checks++; if (data_a !== held) begin errors++; $display("[TB] FAIL rand_a_held[%0d]: got %h expected %h", i, data_a, held); end
            end
        end
        rdy_a = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_random_8e1();
        rdy_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       p_ok, bad, p;
            int         e_acc, e_fe, e_pe;
            d    = 8'($urandom);
            p_ok = ($urandom_range(0, 2) != 0);
            bad  = ($urandom_range(0, 4) == 0);
            p    = 1'(($countones(d) % 2) == 1) ^ !p_ok;
            snap_b();
            send_bits(1, frame_b(d, p, !bad), 11);
            rx_b = 1'b1;
            wait_clks(64);
            e_acc = 0; e_fe = 0; e_pe = 0;
            if (bad)        e_fe = 1;
            else if (!p_ok) e_pe = 1;
            else            e_acc = 1;
            checks++; if (acc_b - s_acc !== e_acc || fec_b - s_fe !== e_fe || pec_b - s_pe !== e_pe) begin
                errors++; $display("[TB] FAIL rand_b_events[%0d]: got acc=%0d fe=%0d pe=%0d expected acc=%0d fe=%0d pe=%0d", i, acc_b - s_acc, fec_b - s_fe, pec_b - s_pe, e_acc, e_fe, e_pe);
            end
            if (e_acc == 1) begin
                checks++; if (last_b !== d) begin errors++; $display("[TB] FAIL rand_b_data[%0d]: got %h expected %h", i, last_b, d); end
            end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (multi_err !== 0) begin errors++; $display("[TB] FAIL error_exclusive: got %0d overlapping cycles expected 0", multi_err); end
        checks++; if (ovc_b !== 0) begin errors++; $display("[TB] FAIL no_overrun_b: got %0d expected 0", ovc_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_parity();
        test_overrun();
        test_reset_mid();
        test_random_8n1();
        test_random_8e1();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
